// File: rtl/sum_latch_uart_tx_n_if.sv
// Operand/result bundle between the input-pin operand bus and the sum/latch/UART block.
interface sum_latch_uart_tx_n_if #(
    parameter int unsigned CH_W   = 8,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned SUM_W = CH_W + $clog2(NUM_CH);

    logic [NUM_CH*CH_W-1:0] op_flat;
    logic [NUM_CH-1:0]      ch_mask;
    logic                   mode;
    logic                   latch;
    logic                   acc_clr;
    logic [SUM_W-1:0]       sum_q;
    logic                   busy;
    logic                   dropped;
    logic                   ovf;
    logic                   tx;

    modport master (
        output op_flat, ch_mask, mode, latch, acc_clr,
        input  sum_q, busy, dropped, ovf, tx
    );

    modport slave (
        input  op_flat, ch_mask, mode, latch, acc_clr,
        output sum_q, busy, dropped, ovf, tx
    );
endinterface

// File: rtl/sum_latch_uart_tx_n.sv
// Masked multi-channel sum (snapshot or accumulate), latched into a holding
// register and serialised LSB byte first over an 8N1 UART line (optional even parity).
module sum_latch_uart_tx_n #(
    parameter int unsigned CH_W         = 8,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sum_latch_uart_tx_n_if.slave  bus
);
    localparam int unsigned SUM_W  = CH_W + $clog2(NUM_CH);
    localparam int unsigned NBYTES = (SUM_W + 7) / 8;
    localparam int unsigned PAD_W  = NBYTES * 8;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n, bit_nx;
    logic [BI_W-1:0]  byte_idx, byte_idx_n;
    logic             tx_r, tx_n;
    logic             busy_r, busy_n;

    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] sum_q_r;
    logic [SUM_W-1:0] acc, acc_base, acc_sum;
    logic             acc_carry;
    logic             ovf_r, ovf_base;
    logic             dropped_r;
    logic             accept;
    logic [PAD_W-1:0] sum_pad;
    logic [7:0]       cur_byte;

    always_comb begin
        sum_s = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.ch_mask[i]) begin
                sum_s = sum_s + SUM_W'(bus.op_flat[i*CH_W +: CH_W]);
            end
        end
    end

    assign accept = bus.latch & ~busy_r;

    // Clear is applied before the add so clear+latch in one cycle yields acc = S.
    always_comb begin
        acc_base = bus.acc_clr ? '0 : acc;
        ovf_base = ~bus.acc_clr & ovf_r;
        {acc_carry, acc_sum} = {1'b0, acc_base} + {1'b0, sum_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q_r   <= '0;
            acc       <= '0;
            ovf_r     <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            dropped_r <= bus.latch & busy_r;
            if (accept) begin
                sum_q_r <= bus.mode ? acc_sum : sum_s;
            end
            if (accept && bus.mode) begin
                acc   <= acc_sum;
                ovf_r <= ovf_base | acc_carry;
            end else begin
                acc   <= acc_base;
                ovf_r <= ovf_base;
            end
        end
    end

    always_comb begin
        sum_pad = '0;
        sum_pad[SUM_W-1:0] = sum_q_r;
        cur_byte = sum_pad[byte_idx*8 +: 8];
    end

    assign bit_nx = bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            tx_r     <= tx_n;
            busy_r   <= busy_n;
        end
    end

    // tx_n is the line level for the state being entered, keeping tx a pure register.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        tx_n       = tx_r;
        busy_n     = busy_r;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (accept) begin
                    state_n    = S_START;
                    cnt_n      = CNT_RELOAD;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    state_n   = S_DATA;
                    cnt_n     = CNT_RELOAD;
                    bit_idx_n = '0;
                    tx_n      = cur_byte[0];
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    cnt_n = CNT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_n = S_PARITY;
                            tx_n    = ^cur_byte;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_nx;
                        tx_n      = cur_byte[bit_nx];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == '0) begin
                    state_n = S_STOP;
                    cnt_n   = CNT_RELOAD;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    cnt_n = CNT_RELOAD;
                    if (32'(byte_idx) < NBYTES - 1) begin
                        byte_idx_n = byte_idx + 1'b1;
                        state_n    = S_START;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.sum_q   = sum_q_r;
    assign bus.busy    = busy_r;
    assign bus.dropped = dropped_r;
    assign bus.ovf     = ovf_r;
    assign bus.tx      = tx_r;
endmodule

// File: tb/tb_sum_latch_uart_tx_n.sv
// Directed bench: two instances (no parity / even parity), CLKS_PER_BIT=4, 10-bit sum, 2 bytes.
module tb_sum_latch_uart_tx_n;
    localparam int CPB = 4;
    localparam int W   = 120;

    logic        clk = 1'b0;
    logic        rst0, rst1, sel;
    logic [31:0] op_flat;
    logic [3:0]  ch_mask;
    logic        mode, latch, acc_clr;

    always #5 clk = ~clk;

    sum_latch_uart_tx_n_if #(.CH_W(8), .NUM_CH(4)) b0 ();
    sum_latch_uart_tx_n_if #(.CH_W(8), .NUM_CH(4)) b1 ();

    assign b0.op_flat = op_flat;
    assign b1.op_flat = op_flat;
    assign b0.ch_mask = ch_mask;
    assign b1.ch_mask = ch_mask;
    assign b0.mode    = mode;
    assign b1.mode    = mode;
    assign b0.acc_clr = acc_clr;
    assign b1.acc_clr = acc_clr;
    assign b0.latch   = latch & ~sel;
    assign b1.latch   = latch & sel;

    sum_latch_uart_tx_n #(.CH_W(8), .NUM_CH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(b0)
    );
    sum_latch_uart_tx_n #(.CH_W(8), .NUM_CH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(b1)
    );

    logic       tx_m, busy_m, drop_m, ovf_m;
    logic [9:0] sum_m;
    assign tx_m   = sel ? b1.tx      : b0.tx;
    assign busy_m = sel ? b1.busy    : b0.busy;
    assign drop_m = sel ? b1.dropped : b0.dropped;
    assign ovf_m  = sel ? b1.ovf     : b0.ovf;
    assign sum_m  = sel ? b1.sum_q   : b0.sum_q;

    logic       tr_tx   [W];
    logic       tr_busy [W];
    logic       tr_drop [W];
    logic [9:0] tr_sum  [W];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One latch pulse, then W cycles recorded at negedges; optional extra latch
    // (with changed operands) and optional one-edge reset during the window.
    task automatic frame(input int drop_at, input int drop_len, input int rst_at);
        @(negedge clk);
        latch = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            tr_tx[i]   = tx_m;
            tr_busy[i] = busy_m;
            tr_drop[i] = drop_m;
            tr_sum[i]  = sum_m;
            if (i == 0) begin
                latch   = 1'b0;
                acc_clr = 1'b0;
            end
            if (i == drop_at) begin
                latch   = 1'b1;
                op_flat = 32'h0101_0101;
            end
            if (drop_at >= 0 && i == drop_at + drop_len) latch = 1'b0;
            if (i == rst_at) begin
                if (sel) rst1 = 1'b1; else rst0 = 1'b1;
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst0 = 1'b0;
                rst1 = sel ? 1'b0 : rst1;
            end
        end
    endtask

    function automatic logic [10:0] frame_bits(input int k, input int par);
        logic [10:0] b = '0;
        int f = 10 + par;
        for (int j = 0; j < f; j++) b[j] = tr_tx[(k*f + j)*CPB + 1];
        return b;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(tr_busy[i]);
        return n;
    endfunction

    function automatic int count_drop();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(tr_drop[i]);
        return n;
    endfunction

    task automatic check_bytes(input string tag, input int par,
                               input logic [7:0] e0, input logic p0,
                               input logic [7:0] e1, input logic p1);
        logic [10:0] fb;
        for (int k = 0; k < 2; k++) begin
            fb = frame_bits(k, par);
            check($sformatf("%s.b%0d.start", tag, k), 32'(fb[0]), 32'd0);
            check($sformatf("%s.b%0d.data", tag, k), 32'(fb[8:1]), 32'(k == 0 ? e0 : e1));
            if (par != 0) check($sformatf("%s.b%0d.parity", tag, k), 32'(fb[9]), 32'(k == 0 ? p0 : p1));
            check($sformatf("%s.b%0d.stop", tag, k), 32'(fb[9 + par]), 32'd1);
        end
    endtask

    initial begin
        int n;
        sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
        op_flat = '0; ch_mask = '0; mode = 1'b0; latch = 1'b0; acc_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        check("rst.sum_q", 32'(sum_m), 32'h0);
        check("rst.busy", 32'(busy_m), 32'd0);
        check("rst.tx", 32'(tx_m), 32'd1);
        check("rst.ovf", 32'(ovf_m), 32'd0);
        check("rst.dropped", 32'(drop_m), 32'd0);

        // Snapshot of all-ones operands
        op_flat = 32'hFFFF_FFFF; ch_mask = 4'b1111; mode = 1'b0;
        frame(-1, 0, -1);
        check("t1.start_next_cycle", 32'(tr_tx[0]), 32'd0);
        check("t1.sum_q", 32'(tr_sum[0]), 32'h3FC);
        check("t1.busy_cycles", 32'(count_busy()), 32'd80);
        check("t1.busy_last", 32'(tr_busy[79]), 32'd1);
        check("t1.busy_fall", 32'(tr_busy[80]), 32'd0);
        check_bytes("t1", 0, 8'hFC, 1'b0, 8'h03, 1'b0);

        // Channel masking
        op_flat = 32'h281E_140A; ch_mask = 4'b0101;
        frame(-1, 0, -1);
        check("t2.sum_q", 32'(tr_sum[0]), 32'h028);
        check_bytes("t2", 0, 8'h28, 1'b0, 8'h00, 1'b0);
        ch_mask = 4'b0000;
        frame(-1, 0, -1);
        check("t2.zero_mask", 32'(tr_sum[0]), 32'h000);
        check_bytes("t2z", 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Latch while busy: single and held
        op_flat = 32'hFFFF_FFFF; ch_mask = 4'b1111;
        frame(30, 1, -1);
        check("t3.drop_count", 32'(count_drop()), 32'd1);
        check("t3.sum_kept", 32'(tr_sum[W-1]), 32'h3FC);
        check("t3.busy_cycles", 32'(count_busy()), 32'd80);
        check_bytes("t3", 0, 8'hFC, 1'b0, 8'h03, 1'b0);
        op_flat = 32'hFFFF_FFFF;
        frame(20, 4, -1);
        check("t3.held_drops", 32'(count_drop()), 32'd4);
        check("t3.held_sum", 32'(tr_sum[W-1]), 32'h3FC);

        // Accumulate with carry, then clear+latch together
        op_flat = 32'hFFFF_FFFF; mode = 1'b1;
        frame(-1, 0, -1);
        check("t4.acc1", 32'(tr_sum[0]), 32'h3FC);
        check("t4.ovf1", 32'(ovf_m), 32'd0);
        frame(-1, 0, -1);
        check("t4.acc2", 32'(tr_sum[0]), 32'h3F8);
        check("t4.ovf2", 32'(ovf_m), 32'd1);
        check_bytes("t4", 0, 8'hF8, 1'b0, 8'h03, 1'b0);
        acc_clr = 1'b1;
        frame(-1, 0, -1);
        check("t4.clr_sum", 32'(tr_sum[0]), 32'h3FC);
        check("t4.clr_ovf", 32'(ovf_m), 32'd0);

        // Reset in the middle of a frame
        mode = 1'b0;
        frame(-1, 0, 25);
        check("t5.tx", 32'(tr_tx[26]), 32'd1);
        check("t5.busy", 32'(tr_busy[26]), 32'd0);
        check("t5.sum_q", 32'(tr_sum[26]), 32'h0);
        n = 0;
        for (int i = 26; i < W; i++) n += int'(!tr_tx[i]);
        check("t5.tx_quiet", 32'(n), 32'd0);
        frame(-1, 0, -1);
        check("t5.after_sum", 32'(tr_sum[0]), 32'h3FC);
        check("t5.after_busy", 32'(count_busy()), 32'd80);
        check_bytes("t5", 0, 8'hFC, 1'b0, 8'h03, 1'b0);

        // Even parity instance
        sel = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        op_flat = 32'hFFFF_FFFF; ch_mask = 4'b1111;
        frame(-1, 0, -1);
        check("t6.sum_q", 32'(tr_sum[0]), 32'h3FC);
        check("t6.busy_cycles", 32'(count_busy()), 32'd88);
        check("t6.busy_fall", 32'(tr_busy[88]), 32'd0);
        check_bytes("t6", 1, 8'hFC, 1'b0, 8'h03, 1'b0);
        op_flat = 32'h0000_0001;
        frame(-1, 0, -1);
        check("t6.sum_one", 32'(tr_sum[0]), 32'h001);
        check_bytes("t6b", 1, 8'h01, 1'b1, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
